boss_hit_scheduler: RTL

Sequences a complete boss encounter and time-shares a single boss/bullet collision comparator among all player-bullet slots. It owns the boss life cycle: spawn, fight, explode, respawn. It tracks boss health and issues one-cycle kill pulses back to the bullet pool. It sits between the bullet pool, the boss movement logic and the renderer, which consumes `boss_en`, `boom` and `revive`.

---
 rtl/boss_hit_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/boss_hit_scheduler.sv
// Boss encounter sequencer: spawn, fight, explode, respawn.
// One shared window comparator is time-multiplexed over the bullet slots by a round-robin pointer.
`timescale 1ns/1ps
module boss_hit_scheduler #(
    parameter int N_BULLETS      = 4,
    parameter int MAX_HEALTH     = 8,
    parameter int HIT_GUARD      = 4,
    parameter int EXPLODE_CYCLES = 1024,
    parameter int RESPAWN_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [9:0]              boss_x,
    input  logic [9:0]              boss_y,
    input  logic [N_BULLETS-1:0]    bullet_valid,
    input  logic [10*N_BULLETS-1:0] bullet_x,
    input  logic [10*N_BULLETS-1:0] bullet_y,
    output logic [N_BULLETS-1:0]    bullet_kill,
    output logic                    boss_en,
    output logic [3:0]              boss_health,
    output logic                    boom,
    output logic                    revive,
    output logic                    hit,
    output logic [2:0]              state
);

    localparam int PW   = $clog2(N_BULLETS);
    localparam int GW   = (HIT_GUARD < 1) ? 1 : $clog2(HIT_GUARD + 1);
    localparam int TMAX = (EXPLODE_CYCLES > RESPAWN_CYCLES) ? EXPLODE_CYCLES : RESPAWN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] L_PTR_LAST   = PW'(N_BULLETS - 1);
    localparam logic [PW-1:0] L_PTR_ONE    = PW'(1);
    localparam logic [GW-1:0] L_GUARD_LOAD = GW'(HIT_GUARD);
    localparam logic [GW-1:0] L_GUARD_ONE  = GW'(1);
    localparam logic [TW-1:0] L_EXP_LOAD   = TW'(EXPLODE_CYCLES - 1);
    localparam logic [TW-1:0] L_RSP_LOAD   = TW'(RESPAWN_CYCLES - 1);
    localparam logic [TW-1:0] L_T_ONE      = TW'(1);
    localparam logic [3:0]    L_HEALTH_MAX = 4'(MAX_HEALTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPAWN   = 3'd1,
        S_FIGHT   = 3'd2,
        S_EXPLODE = 3'd3,
        S_RESPAWN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_ptr;
    logic [GW-1:0]         r_guard;
    logic [TW-1:0]         r_timer;
    logic [3:0]            r_health;
    logic [N_BULLETS-1:0]  r_kill;
    logic                  r_hit;
    logic                  r_boss_en;
    logic                  r_boom;
    logic                  r_revive;

    logic                  w_sel_valid;
    logic [9:0]            w_sel_x;
    logic [9:0]            w_sel_y;
    logic                  w_hit;
    logic [N_BULLETS-1:0]  w_kill;
    logic [3:0]            w_health_dec;

    // Window test in 11 bits so boss_x + 128 and bx + 10 never wrap.
    function automatic logic f_in_window(input logic [9:0] bx, input logic [9:0] by,
                                         input logic [9:0] bsx, input logic [9:0] bsy);
        logic x_ok;
        logic y_ok;
        x_ok = (({1'b0, bx} + 11'd10) >= {1'b0, bsx}) && ({1'b0, bx} < ({1'b0, bsx} + 11'd128));
        y_ok = (({1'b0, by} + 11'd40) >  {1'b0, bsy}) && ({1'b0, by} < ({1'b0, bsy} + 11'd128));
        return x_ok && y_ok;
    endfunction

    // Slot mux, hit judgement and one-hot kill vector for the slot under the pointer.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_x     = 10'd0;
        w_sel_y     = 10'd0;
        for (int i = 0; i < N_BULLETS; i++) begin
            w_sel_valid = w_sel_valid | (bullet_valid[i] & (r_ptr == PW'(i)));
            w_sel_x     = w_sel_x | (bullet_x[10*i +: 10] & {10{r_ptr == PW'(i)}});
            w_sel_y     = w_sel_y | (bullet_y[10*i +: 10] & {10{r_ptr == PW'(i)}});
        end
        w_hit = (r_state == S_FIGHT) && w_sel_valid && (r_guard == {GW{1'b0}}) &&
                f_in_window(w_sel_x, w_sel_y, boss_x, boss_y);
        w_kill = {N_BULLETS{1'b0}};
        for (int i = 0; i < N_BULLETS; i++) begin
            w_kill[i] = w_hit & (r_ptr == PW'(i));
        end
        w_health_dec = (r_health == 4'd0) ? 4'd0 : (r_health - 4'd1);
    end

    // Encounter next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SPAWN;
                else       w_next = S_IDLE;
            end
            S_SPAWN: w_next = S_FIGHT;
            S_FIGHT: begin
                if (w_hit && (w_health_dec == 4'd0)) w_next = S_EXPLODE;
                else                                 w_next = S_FIGHT;
            end
            S_EXPLODE: begin
                if (r_timer == {TW{1'b0}}) w_next = S_RESPAWN;
                else                       w_next = S_EXPLODE;
            end
            S_RESPAWN: begin
                if (r_timer == {TW{1'b0}}) w_next = S_SPAWN;
                else                       w_next = S_RESPAWN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Datapath: pointer, guard, shared explode/respawn timer, health and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= {PW{1'b0}};
            r_guard   <= {GW{1'b0}};
            r_timer   <= {TW{1'b0}};
            r_health  <= 4'd0;
            r_kill    <= {N_BULLETS{1'b0}};
            r_hit     <= 1'b0;
            r_boss_en <= 1'b0;
            r_boom    <= 1'b0;
            r_revive  <= 1'b0;
        end else begin
            r_kill    <= w_kill;
            r_hit     <= w_hit;
            r_boss_en <= (w_next == S_FIGHT);
            r_boom    <= (w_next == S_EXPLODE);
            r_revive  <= (w_next == S_SPAWN);

            if (w_next == S_SPAWN) r_health <= L_HEALTH_MAX;
            else if (w_hit)        r_health <= w_health_dec;

            if (r_state == S_SPAWN)            r_guard <= {GW{1'b0}};
            else if (w_hit)                    r_guard <= L_GUARD_LOAD;
            else if (r_guard != {GW{1'b0}})    r_guard <= r_guard - L_GUARD_ONE;

            if (r_state == S_FIGHT) begin
                if (r_ptr == L_PTR_LAST) r_ptr <= {PW{1'b0}};
                else                     r_ptr <= r_ptr + L_PTR_ONE;
            end

            // Timer is loaded with length-1 on state entry and the state exits when it reads 0.
            if ((w_next == S_EXPLODE) && (r_state != S_EXPLODE))      r_timer <= L_EXP_LOAD;
            else if ((w_next == S_RESPAWN) && (r_state != S_RESPAWN)) r_timer <= L_RSP_LOAD;
            else if (r_timer != {TW{1'b0}})                           r_timer <= r_timer - L_T_ONE;
        end
    end

    assign state       = r_state;
    assign bullet_kill = r_kill;
    assign hit         = r_hit;
    assign boss_health = r_health;
    assign boss_en     = r_boss_en;
    assign boom        = r_boom;
    assign revive      = r_revive;

endmodule
